systolic_skew_feeder: RTL and testbench

Upstream feeder for the 8x8 output-stationary `systolic` array. It accepts one operand tile per run as SIZE handshaked beats. Beat k is column k of the weight matrix A and row k of the activation matrix X. Lane p of each beat is delayed by p cycles so the array receives the diagonal stagger it requires (A[i][k] on `row_weights[i]` and X[k][j] on `col_activations[j]`, both at base+k+lane). It then flushes zeros, waits for the array to drain, and pulses `tile_done` when `result` is final.

---
 rtl/systolic_skew_feeder_pkg.sv | 19 +
 rtl/systolic_skew_feeder_if.sv | 27 ++
 rtl/systolic_skew_feeder_skew.sv | 33 +++
 rtl/systolic_skew_feeder.sv | 132 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Constants and types shared by the systolic array and its skew feeder.
package systolic_pkg;

  localparam int SIZE         = 8;
  localparam int DATA_WIDTH   = 8;
  // SIZE products of two DATA_WIDTH operands fit without overflow.
  localparam int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_FLUSH,
    ST_DONE
  } feeder_state_t;

  typedef logic [SIZE-1:0][DATA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand/control bundle between the upstream producer, the skew feeder and the array.
interface systolic_skew_feeder_if
  import systolic_pkg::*;
();

  logic      start;
  logic      in_valid;
  logic      in_ready;
  lane_vec_t in_a_col;
  lane_vec_t in_x_row;
  logic      acc_clear;
  lane_vec_t row_weights;
  lane_vec_t col_activations;
  logic      busy;
  logic      tile_done;

  modport master (
    output start, in_valid, in_a_col, in_x_row,
    input  in_ready, acc_clear, row_weights, col_activations, busy, tile_done
  );

  modport slave (
    input  start, in_valid, in_a_col, in_x_row,
    output in_ready, acc_clear, row_weights, col_activations, busy, tile_done
  );

endinterface

// File: rtl/systolic_skew_feeder_skew.sv
// Fixed-depth register delay line; DEPTH=0 degenerates to a wire.
module skew_delay_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int s = 1; s < DEPTH; s++) begin
          stage_q[s] <= stage_q[s-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds one operand tile into the systolic array with a per-lane diagonal stagger,
// then flushes, waits for the array to drain and pulses tile_done.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2 * SIZE
) (
  input logic                  clk,
  input logic                  rst_n,
  systolic_skew_feeder_if.slave bus
);

  // FLUSH must cover the skew of the last beat plus the array drain time.
  localparam int FLUSH_LAST = SIZE - 1 + DRAIN_CYCLES;
  localparam int CNT_W      = $clog2(FLUSH_LAST + 1);

  feeder_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             acc_clear_q;
  logic             busy_q;
  logic             tile_done_q;
  logic             handshake;

  lane_vec_t a_in_d, a_in_q;
  lane_vec_t x_in_d, x_in_q;
  lane_vec_t a_skew, x_skew;

  assign handshake = bus.in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      acc_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      acc_clear_q <= 1'b0;
      tile_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q     <= ST_CLEAR;
            acc_clear_q <= 1'b1;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
          end
        end
        ST_CLEAR: begin
          state_q    <= ST_FEED;
          in_ready_q <= 1'b1;
        end
        ST_FEED: begin
          if (handshake) begin
            if (cnt_q == CNT_W'(SIZE - 1)) begin
              state_q    <= ST_FLUSH;
              in_ready_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (cnt_q == CNT_W'(FLUSH_LAST)) begin
            state_q     <= ST_DONE;
            tile_done_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          cnt_q      <= '0;
        end
      endcase
    end
  end

  // Bubbles and every non-FEED cycle load zeros, which the array accumulates harmlessly.
  assign a_in_d = handshake ? bus.in_a_col : '0;
  assign x_in_d = handshake ? bus.in_x_row : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_in_q <= '0;
      x_in_q <= '0;
    end else begin
      a_in_q <= a_in_d;
      x_in_q <= x_in_d;
    end
  end

  for (genvar p = 0; p < SIZE; p++) begin : g_lane
    skew_delay_line #(
      .DEPTH (p),
      .WIDTH (DATA_WIDTH)
    ) u_a_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (a_in_q[p]),
      .q_o   (a_skew[p])
    );

    skew_delay_line #(
      .DEPTH (p),
      .WIDTH (DATA_WIDTH)
    ) u_x_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (x_in_q[p]),
      .q_o   (x_skew[p])
    );
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.acc_clear       = acc_clear_q;
  assign bus.busy            = busy_q;
  assign bus.tile_done       = tile_done_q;
  assign bus.row_weights     = a_skew;
  assign bus.col_activations = x_skew;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench: a timeline model predicts every output cycle, and a behavioural
// output-stationary array turns the lanes into a result checked at tile_done.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int S          = SIZE;
  localparam int D          = 2 * SIZE;
  localparam int RW         = RESULT_WIDTH;
  localparam int RESET_HOLD = 2;

  typedef struct {
    int        c;
    logic [3:0] ctrl;
    lane_vec_t rw;
    lane_vec_t ca;
  } exp_t;

  typedef logic [S-1:0][S-1:0][RW-1:0] res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  exp_t expQ[$];
  res_t resQ[$];

  lane_vec_t planA [S];
  lane_vec_t planX [S];
  int        planE [S];
  int        planS, planL, planT;

  logic [RW-1:0]         acc [S][S] = '{default: '0};
  logic [DATA_WIDTH-1:0] pa  [S][S] = '{default: '0};
  logic [DATA_WIDTH-1:0] px  [S][S] = '{default: '0};

  systolic_skew_feeder_if bus();

  systolic_skew_feeder #(
    .DRAIN_CYCLES (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs in cycle c of the planned run, from beat accept times alone.
  function automatic exp_t modelAt(int c);
    exp_t e;
    e.c    = c;
    e.ctrl = {(c >= planS + 2 && c <= planL), (c == planS + 1),
              (c >= planS + 1 && c <= planT), (c == planT)};
    e.rw   = '0;
    e.ca   = '0;
    for (int k = 0; k < S; k++)
      for (int p = 0; p < S; p++)
        if (planE[k] + 1 + p == c) begin
          e.rw[p] = planA[k][p];
          e.ca[p] = planX[k][p];
        end
    return e;
  endfunction

  function automatic exp_t idleAt(int c);
    exp_t e;
    e.c    = c;
    e.ctrl = '0;
    e.rw   = '0;
    e.ca   = '0;
    return e;
  endfunction

  function automatic res_t matmul();
    res_t r;
    r = '0;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        for (int k = 0; k < S; k++)
          r[i][j] = r[i][j] + RW'(planA[k][i]) * RW'(planX[k][j]);
    return r;
  endfunction

  function automatic lane_vec_t rndVec(int maxv);
    lane_vec_t v;
    for (int p = 0; p < S; p++) v[p] = DATA_WIDTH'($urandom_range(0, maxv));
    return v;
  endfunction

  task automatic driveCycle(input logic st, input logic v, input lane_vec_t a, input lane_vec_t x);
    bus.start    = st;
    bus.in_valid = v;
    bus.in_a_col = a;
    bus.in_x_row = x;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      expQ.push_back(idleAt(cyc));
      driveCycle(1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0, rndVec(255), rndVec(255));
    end
  endtask

  task automatic setDiag(input int av, input int xv);
    for (int k = 0; k < S; k++)
      for (int p = 0; p < S; p++) begin
        planA[k][p] = (p == k) ? DATA_WIDTH'(av) : '0;
        planX[k][p] = (p == k) ? DATA_WIDTH'(xv) : '0;
      end
  endtask

  task automatic fillRandom();
    for (int k = 0; k < S; k++) begin
      planA[k] = rndVec(255);
      planX[k] = rndVec(255);
    end
  endtask

  // Plans one run from the current cycle, queues its expectations, then drives it.
  task automatic applyStimulus(input int maxGap, input bit noise, input int abortBeats);
    int        t, abortCyc, lastC, beat;
    logic      st, v;
    lane_vec_t a, x;
    planS = cyc;
    t = planS + 2;
    for (int k = 0; k < S; k++) begin
      if (maxGap > 0) t = t + int'($urandom_range(0, maxGap));
      planE[k] = t;
      t = t + 1;
    end
    planL    = planE[S-1];
    planT    = planL + S + 1 + D;
    abortCyc = (abortBeats > 0) ? planE[abortBeats-1] + 1 : planT + 1;
    lastC    = abortCyc - 1;
    for (int c = planS; c <= lastC; c++) expQ.push_back(modelAt(c));
    if (abortBeats == 0) resQ.push_back(matmul());
    else for (int c = abortCyc; c < abortCyc + RESET_HOLD; c++) expQ.push_back(idleAt(c));

    for (int c = planS; c <= lastC; c++) begin
      beat = -1;
      for (int k = 0; k < S; k++) if (planE[k] == c) beat = k;
      st = (c == planS) || (noise && ($urandom_range(0, 3) == 0));
      a  = rndVec(255);
      x  = rndVec(255);
      if (beat >= 0) begin
        v = 1'b1;
        a = planA[beat];
        x = planX[beat];
      end else if (c >= planS + 2 && c <= planL) begin
        v = 1'b0;
      end else begin
        v = noise && ($urandom_range(0, 1) == 1);
      end
      driveCycle(st, v, a, x);
    end

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    if (abortBeats > 0) begin
      rst_n = 1'b0;
      repeat (RESET_HOLD) begin
        @(posedge clk);
        #1;
      end
      rst_n = 1'b1;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0] gotCtrl;
    compared++;
    if (e.c != cyc) begin
      mismatched++;
      $display("[TB] FAIL stale_expectation cyc=%0d got=%0d required=%0d", cyc, cyc, e.c);
      return;
    end
    gotCtrl = {bus.in_ready, bus.acc_clear, bus.busy, bus.tile_done};
    if (gotCtrl !== e.ctrl) begin
      mismatched++;
      $display("[TB] FAIL ctrl{rdy,clr,busy,done} cyc=%0d got=%b required=%b", cyc, gotCtrl, e.ctrl);
    end
    compared++;
    if ({bus.row_weights, bus.col_activations} !== {e.rw, e.ca}) begin
      mismatched++;
      $display("[TB] FAIL lanes cyc=%0d got=%h/%h required=%h/%h",
               cyc, bus.row_weights, bus.col_activations, e.rw, e.ca);
    end
  endtask

  task automatic checkResult();
    res_t r;
    int   bi, bj;
    compared++;
    if (resQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL unexpected_tile_done cyc=%0d got=1 required=0", cyc);
      return;
    end
    r  = resQ.pop_front();
    bi = -1;
    bj = -1;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        if (bi < 0 && acc[i][j] !== r[i][j]) begin
          bi = i;
          bj = j;
        end
    if (bi >= 0) begin
      mismatched++;
      $display("[TB] FAIL result[%0d][%0d] cyc=%0d got=%0d required=%0d",
               bi, bj, cyc, acc[bi][bj], r[bi][bj]);
    end
  endtask

  // Monitor: checks due expectations, then advances the downstream array by one cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0 && expQ[0].c <= cyc) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
      if (bus.tile_done === 1'b1) checkResult();
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++)
          acc[i][j] = bus.acc_clear ? '0 : acc[i][j] + RW'(pa[i][j]) * RW'(px[i][j]);
      for (int i = 0; i < S; i++)
        for (int j = S - 1; j > 0; j--) pa[i][j] = pa[i][j-1];
      for (int j = 0; j < S; j++)
        for (int i = S - 1; i > 0; i--) px[i][j] = px[i-1][j];
      for (int i = 0; i < S; i++) pa[i][0] = bus.row_weights[i];
      for (int j = 0; j < S; j++) px[0][j] = bus.col_activations[j];
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a_col = '0;
    bus.in_x_row = '0;
    @(posedge clk);
    #1;
    idleCycles(3, 1'b0);
    rst_n = 1'b1;
    idleCycles(2, 1'b1);

    $display("[TB] identity tile A=I X=2I");
    setDiag(1, 2);
    applyStimulus(0, 1'b0, 0);
    idleCycles(2, 1'b0);

    $display("[TB] lane skew probe");
    for (int k = 0; k < S; k++) begin
      planA[k] = '0;
      planX[k] = '0;
    end
    for (int p = 0; p < S; p++) begin
      planA[0][p] = DATA_WIDTH'(p + 1);
      planX[0][p] = DATA_WIDTH'(p + 1);
    end
    applyStimulus(0, 1'b0, 0);
    idleCycles(1, 1'b0);

    $display("[TB] bubbles A=1 X=3");
    for (int k = 0; k < S; k++)
      for (int p = 0; p < S; p++) begin
        planA[k][p] = 8'd1;
        planX[k][p] = 8'd3;
      end
    applyStimulus(2, 1'b0, 0);
    idleCycles(1, 1'b0);

    $display("[TB] protocol noise");
    fillRandom();
    applyStimulus(1, 1'b1, 0);
    idleCycles(2, 1'b1);

    $display("[TB] reset mid-FEED then fresh run");
    fillRandom();
    applyStimulus(1, 1'b0, 3);
    idleCycles(20, 1'b0);
    setDiag(1, 2);
    applyStimulus(0, 1'b0, 0);

    $display("[TB] back-to-back tiles");
    fillRandom();
    applyStimulus(0, 1'b0, 0);
    setDiag(1, 5);
    applyStimulus(0, 1'b0, 0);

    $display("[TB] random tiles");
    repeat (3) begin
      fillRandom();
      applyStimulus(2, 1'b1, 0);
    end
    idleCycles(4, 1'b0);

    compared++;
    if (expQ.size() != 0 || resQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL leftover_expectations got=%0d/%0d required=0/0", expQ.size(), resQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
